mem_cmd_initiator: RTL

MEM_CMD_INITIATOR -- requirements
Module: mem_cmd_initiator

---
 rtl/mem_cmd_initiator_pkg.sv | 22 ++
 rtl/mem_cmd_framer.sv | 27 ++
 rtl/mem_cmd_initiator.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mem_cmd_initiator_pkg.sv
// Shared types and constants for the memory command initiator:
// FSM state encoding, frame layout and response constants.
package mem_cmd_initiator_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX_BYTE,
        TX_GAP,
        RX_WAIT,
        DONE
    } state_t;

    localparam int         OPCODE_BIT = 7;
    localparam logic [7:0] ACK_BYTE   = 8'hA5;
    localparam int         READ_LEN   = 2;
    localparam int         WRITE_LEN  = 4;

    function automatic logic [1:0] last_tx_idx(input logic is_write);
        return is_write ? 2'(WRITE_LEN - 1) : 2'(READ_LEN - 1);
    endfunction

endpackage

// File: rtl/mem_cmd_framer.sv
// Combinational mapping of the captured request and byte index to the
// UART byte to send.
module mem_cmd_framer
    import mem_cmd_initiator_pkg::*;
(
    input  logic        write,
    input  logic [3:0]  select,
    input  logic [7:0]  addr,
    input  logic [15:0] wdata,
    input  logic [1:0]  byte_idx,
    output logic [7:0]  tx_data
);

    always_comb begin
        tx_data = '0;
        case (byte_idx)
            2'd0: begin
                tx_data[OPCODE_BIT] = write;
                tx_data[3:0]        = select;
            end
            2'd1:    tx_data = addr;
            2'd2:    tx_data = wdata[15:8];
            default: tx_data = wdata[7:0];
        endcase
    end

endmodule

// File: rtl/mem_cmd_initiator.sv
// UART memory command initiator: frames a read/write request into bytes and
// collects the response. Optional response timeout under `RSP_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | accepting a request
// TX_BYTE | pulse uart_tx_en once the transmitter is free
// TX_GAP  | hold byte until transmitter free, then next byte or RX_WAIT
// RX_WAIT | collect response bytes (optional timeout)
// DONE    | one-cycle rsp_valid
module mem_cmd_initiator
    import mem_cmd_initiator_pkg::*;
#(
    parameter int MEM_SELECT_BITS = 4,
    parameter int RSP_TIMEOUT     = 1_200_000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [MEM_SELECT_BITS-1:0] req_select,
    input  logic [7:0]                 req_addr,
    input  logic [15:0]                req_wdata,
    output logic                       rsp_valid,
    output logic [15:0]                rsp_rdata,
    output logic                       rsp_error,
    output logic                       uart_tx_en,
    output logic [7:0]                 uart_tx_data,
    input  logic                       uart_tx_busy,
    input  logic                       uart_rx_valid,
    input  logic [7:0]                 uart_rx_data
);

    if (MEM_SELECT_BITS < 1 || MEM_SELECT_BITS > 4 || RSP_TIMEOUT < 1) begin : g_bad_param
        $error("mem_cmd_initiator: parameter out of range");
    end

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        write_q, write_d;
    logic [3:0]  select_q, select_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        rx_cnt_q, rx_cnt_d;
    logic [7:0]  rx_hi_q, rx_hi_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;
    logic        last_tx, rx_last, tmo_hit;

    assign last_tx = (byte_cnt_q == last_tx_idx(write_q));
    assign rx_last = write_q | rx_cnt_q;

`ifdef RSP_TIMEOUT_EN
    localparam int TMO_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Down-counter reloaded on RX_WAIT entry and on every accepted byte.
    always_comb begin
        tmo_d = tmo_q;
        if ((state_q == TX_GAP && state_d == RX_WAIT) || (state_q == RX_WAIT && rx_valid_q))
            tmo_d = TMO_W'(RSP_TIMEOUT - 1);
        else if (state_q == RX_WAIT && tmo_q != '0)
            tmo_d = tmo_q - TMO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end

    assign tmo_hit = (tmo_q == '0);
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = TX_BYTE;
            TX_BYTE: if (!uart_tx_busy) state_d = TX_GAP;
            TX_GAP:  if (!uart_tx_busy) state_d = last_tx ? RX_WAIT : TX_BYTE;
            RX_WAIT: begin
                if (rx_valid_q) begin
                    if (rx_last) state_d = DONE;
                end else if (tmo_hit) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        uart_tx_en = (state_q == TX_BYTE) && !uart_tx_busy;
        rsp_valid  = (state_q == DONE);
    end

    // Registering the strobe gives the two-cycle rx-to-rsp_valid latency;
    // strobes outside RX_WAIT are dropped here so nothing is buffered.
    always_comb begin
        write_d     = write_q;
        select_d    = select_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        byte_cnt_d  = byte_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        rx_hi_d     = rx_hi_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        rx_valid_d  = uart_rx_valid && (state_q == RX_WAIT);
        rx_data_d   = uart_rx_data;
        case (state_q)
            IDLE: if (req_valid) begin
                write_d    = req_write;
                select_d   = 4'(req_select);
                addr_d     = req_addr;
                wdata_d    = req_wdata;
                byte_cnt_d = 2'd0;
                rx_cnt_d   = 1'b0;
            end
            TX_GAP: if (!uart_tx_busy && !last_tx) byte_cnt_d = byte_cnt_q + 2'd1;
            RX_WAIT: begin
                if (rx_valid_q) begin
                    if (!rx_last) begin
                        rx_hi_d  = rx_data_q;
                        rx_cnt_d = 1'b1;
                    end else if (write_q) begin
                        rsp_rdata_d = 16'h0000;
                        rsp_error_d = (rx_data_q != ACK_BYTE);
                    end else begin
                        rsp_rdata_d = {rx_hi_q, rx_data_q};
                        rsp_error_d = 1'b0;
                    end
                end else if (tmo_hit) begin
                    rsp_rdata_d = 16'h0000;
                    rsp_error_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_q     <= 1'b0;
            select_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            byte_cnt_q  <= '0;
            rx_cnt_q    <= 1'b0;
            rx_hi_q     <= '0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            write_q     <= write_d;
            select_q    <= select_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            byte_cnt_q  <= byte_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_hi_q     <= rx_hi_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

    mem_cmd_framer u_framer (
        .write    (write_q),
        .select   (select_q),
        .addr     (addr_q),
        .wdata    (wdata_q),
        .byte_idx (byte_cnt_q),
        .tx_data  (uart_tx_data)
    );

endmodule
